// File: rtl/top_pkg.sv
// Shared constants and types for the CSI-2 receive data path.
package top_pkg;

    // HS leader / sync pattern that marks the start of every HS burst on a lane.
    localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

    // Aligner control states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT_LANES,
        STREAM
    } align_st_t;

endpackage

// File: rtl/csi_rx_lane_align.sv
// One CSI-2 data lane: polarity fix, sync-byte hunt at all bit offsets,
// offset lock and a small FIFO that absorbs inter-lane skew.
module csi_rx_lane_align
    import top_pkg::*;
#(
    parameter logic       INVERT    = 1'b0,
    parameter logic [7:0] SYNC_BYTE = CSI_SYNC_BYTE,
    parameter int         MAX_SKEW  = 3
) (
    input  logic       byte_clock,
    input  logic       reset,
    input  logic [7:0] deser_in,
    input  logic       wait_for_sync,
    input  logic       clear,
    input  logic       pop,
    output logic       lock_next,
    output logic       locked,
    output logic       fifo_empty,
    output logic [7:0] byte_out
);

    // Depth covers the longest skew wait plus the bypass/pop pipeline slot.
    localparam int DEPTH = MAX_SKEW + 2;
    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [7:0]       d;
    logic [7:0]       d_q;
    logic [15:0]      win;
    logic             match;
    logic [2:0]       match_off;
    logic             locked_q, locked_d;
    logic [2:0]       off_q, off_d;
    logic [7:0]       push_byte;
    logic             push, do_write, do_read;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       mem_q [DEPTH];

    // Build the 16-bit window and find the lowest bit offset holding the sync byte.
    always_comb begin
        d         = deser_in ^ {8{INVERT}};
        win       = {d, d_q};
        match     = 1'b0;
        match_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (win[k +: 8] == SYNC_BYTE) begin
                match     = 1'b1;
                match_off = 3'(k);
            end
        end
    end

    // Lock tracking: a match is only taken while searching; clear always wins.
    always_comb begin
        lock_next = locked_q | (wait_for_sync & match);
        locked_d  = clear ? 1'b0 : lock_next;
        off_d     = off_q;
        if (!locked_q && wait_for_sync && match) begin
            off_d = match_off;
        end
    end

    // FIFO control with fall-through so a byte pushed this cycle can be popped at once.
    always_comb begin
        push_byte  = win[off_q +: 8];
        push       = locked_q & ~clear;
        do_read    = pop & (count_q != '0);
        do_write   = push & ~(pop & (count_q == '0));
        fifo_empty = (count_q == '0) & ~push;
        byte_out   = (count_q == '0) ? push_byte : mem_q[rd_ptr_q];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_write && !do_read) begin
                count_d = count_q + 1'b1;
            end else if (!do_write && do_read) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Lane state registers.
    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            d_q      <= '0;
            locked_q <= 1'b0;
            off_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            d_q      <= d;
            locked_q <= locked_d;
            off_q    <= off_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge byte_clock) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= push_byte;
        end
    end

    // The skew window bounds the fill level, so a write into a full FIFO is a design bug.
    assert property (@(posedge byte_clock) disable iff (reset)
        !(do_write && !do_read && (count_q == FULL_CNT)));

    assign locked = locked_q;

endmodule

// File: rtl/csi_rx_dat_align.sv
// N-lane CSI-2 byte aligner and deskewer: waits for every lane to lock,
// then pops all lanes in lockstep and registers one byte per lane per cycle.
module csi_rx_dat_align
    import top_pkg::*;
#(
    parameter int                NLANES    = 2,
    parameter logic [NLANES-1:0] INVERT    = '0,
    parameter logic [7:0]        SYNC_BYTE = CSI_SYNC_BYTE,
    parameter int                MAX_SKEW  = 3
) (
    input  logic                  byte_clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wait_for_sync,
    input  logic                  packet_done,
    input  logic [NLANES*8-1:0]   deser_in,
    output logic [NLANES*8-1:0]   byte_out,
    output logic                  byte_valid,
    output logic [NLANES-1:0]     lane_locked,
    output logic                  sync_err
);

    localparam int CNT_W = (MAX_SKEW < 2) ? 1 : $clog2(MAX_SKEW + 1);
    localparam logic [CNT_W-1:0] SKEW_LIMIT = CNT_W'(MAX_SKEW);

    align_st_t            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NLANES*8-1:0]  byte_out_q, byte_out_d;
    logic [NLANES*8-1:0]  lane_bytes;
    logic                 byte_valid_q, byte_valid_d;
    logic                 sync_err_q, sync_err_d;
    logic [NLANES-1:0]    lock_next, locked, fifo_empty;
    logic                 kill, timeout, clear, pop;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        csi_rx_lane_align #(
            .INVERT    (INVERT[l]),
            .SYNC_BYTE (SYNC_BYTE),
            .MAX_SKEW  (MAX_SKEW)
        ) u_lane (
            .byte_clock    (byte_clock),
            .reset         (reset),
            .deser_in      (deser_in[8*l +: 8]),
            .wait_for_sync (wait_for_sync),
            .clear         (clear),
            .pop           (pop),
            .lock_next     (lock_next[l]),
            .locked        (locked[l]),
            .fifo_empty    (fifo_empty[l]),
            .byte_out      (lane_bytes[8*l +: 8])
        );
    end

    // Next state and skew timeout; disable and end-of-packet override lock events.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        timeout = 1'b0;
        kill    = ~enable | packet_done;
        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (&lock_next) begin
                        state_d = STREAM;
                    end else if (|lock_next) begin
                        state_d = WAIT_LANES;
                        cnt_d   = '0;
                    end
                end
                WAIT_LANES: begin
                    if (&lock_next) begin
                        state_d = STREAM;
                    end else if (cnt_q == SKEW_LIMIT) begin
                        state_d = IDLE;
                        timeout = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    state_d = STREAM;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        clear = kill | timeout;
    end

    // Lockstep pop and output register inputs.
    always_comb begin
        pop          = (state_q == STREAM) & ~(|fifo_empty) & ~kill;
        byte_valid_d = pop;
        sync_err_d   = timeout;
        byte_out_d   = byte_out_q;
        if (kill) begin
            byte_out_d = '0;
        end else if (pop) begin
            byte_out_d = lane_bytes;
        end
    end

    // Control and output registers.
    always_ff @(posedge byte_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign byte_out    = byte_out_q;
    assign byte_valid  = byte_valid_q;
    assign lane_locked = locked;
    assign sync_err    = sync_err_q;

endmodule
